// File: rtl/lsu_addr_stage.sv
// Load/store access stage: captures the effective address, checks legality, runs one memory
// transaction and returns extended load data or a fault. Optional timeout via LSU_TIMEOUT_EN.
module lsu_addr_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [32:0] adr_sum,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_fault,
    output logic        rsp_wrap
);

    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_issue = 2'd1,
        s_done  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic        wrap_q;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [31:0] sd_q;
    logic [31:0] rsp_data_q;
    logic        fault_q;

    logic        accept;
    logic        in_issue;
    logic        legal_in;
    logic        timeout;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    function automatic logic is_legal(input logic [2:0] f3, input logic st, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = (a[0] == 1'b0);
            3'b010:         ok = (a == 2'b00);
            default:        ok = 1'b0;
        endcase
        // Unsigned variants only exist for loads.
        if (st && f3[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    assign accept   = req_valid && (state_q == s_idle);
    assign in_issue = (state_q == s_issue);
    assign legal_in = is_legal(funct3, is_store, adr_sum[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q;

    // cnt_q counts completed ISSUE cycles, so mem_req stays up for exactly TIMEOUT_CYCLES.
    assign timeout = in_issue && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (in_issue) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            s_idle: begin
                if (accept) begin
                    state_d = legal_in ? s_issue : s_done;
                end
            end
            s_issue: begin
                if (mem_ack || timeout) begin
                    state_d = s_done;
                end
            end
            s_done: begin
                if (rsp_ready) begin
                    state_d = s_idle;
                end
            end
            default: state_d = s_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= s_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        be    = 4'b1111;
        wdata = sd_q;
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{sd_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_q[1:0];
                wdata = {2{sd_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = sd_q;
            end
        endcase
    end

    always_comb begin
        shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        case (f3_q[1:0])
            2'b00: load_ext = f3_q[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = f3_q[2] ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wrap_q     <= 1'b0;
            store_q    <= 1'b0;
            f3_q       <= '0;
            sd_q       <= '0;
            rsp_data_q <= '0;
            fault_q    <= 1'b0;
        end else if (accept) begin
            addr_q     <= adr_sum[31:0];
            wrap_q     <= adr_sum[32];
            store_q    <= is_store;
            f3_q       <= funct3;
            sd_q       <= store_data;
            rsp_data_q <= '0;
            fault_q    <= !legal_in;
        end else if (in_issue && mem_ack) begin
            // Ack wins over a coincident timeout.
            rsp_data_q <= store_q ? 32'h0 : load_ext;
            fault_q    <= 1'b0;
        end else if (timeout) begin
            rsp_data_q <= '0;
            fault_q    <= 1'b1;
        end
    end

    assign req_ready = (state_q == s_idle);
    assign mem_req   = in_issue;
    assign mem_we    = in_issue && store_q;
    assign mem_addr  = in_issue ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be    = in_issue ? be : 4'b0000;
    assign mem_wdata = (in_issue && store_q) ? wdata : 32'h0;

    assign rsp_valid = (state_q == s_done);
    assign rsp_data  = rsp_valid ? rsp_data_q : 32'h0;
    assign rsp_fault = rsp_valid && fault_q;
    assign rsp_wrap  = rsp_valid && wrap_q;

endmodule

// File: tb/tb_lsu_addr_stage.sv
// Directed bench for lsu_addr_stage: inputs driven and outputs checked on the falling edge.
module tb_lsu_addr_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [32:0] adr_sum;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic        rsp_wrap;

    int total = 0;
    int bad   = 0;

    lsu_addr_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .adr_sum    (adr_sum),
        .is_store   (is_store),
        .funct3     (funct3),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault),
        .rsp_wrap   (rsp_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer an access in cycle 0, then scramble the inputs; returns at the cycle-1 falling edge.
    task automatic issue(input logic [32:0] a, input logic st, input logic [2:0] f3,
                         input logic [31:0] sd);
        req_valid  = 1'b1;
        adr_sum    = a;
        is_store   = st;
        funct3     = f3;
        store_data = sd;
        @(negedge clk);
        req_valid  = 1'b0;
        adr_sum    = ~a;
        is_store   = ~st;
        funct3     = ~f3;
        store_data = ~sd;
    endtask

    // From the cycle-1 falling edge, raise mem_ack in cycle k; returns in cycle k+1.
    task automatic complete(input int k, input logic [31:0] rd);
        repeat (k - 1) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        adr_sum    = '0;
        is_store   = 1'b0;
        funct3     = '0;
        store_data = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x1000, ack in cycle 3, response in cycle 4
        chk("lw_ready", req_ready, 1);
        issue(33'h0_0000_1000, 1'b0, 3'b010, 32'h0);
        chk("lw_mem_req", mem_req, 1);
        chk("lw_mem_addr", mem_addr, 32'h0000_1000);
        chk("lw_mem_be", mem_be, 4'b1111);
        chk("lw_mem_we", mem_we, 0);
        chk("lw_busy", req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("lw_addr_hold", mem_addr, 32'h0000_1000);
        chk("lw_no_rsp_c3", rsp_valid, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("lw_rsp_valid_c4", rsp_valid, 1);
        chk("lw_rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("lw_rsp_fault", rsp_fault, 0);
        chk("lw_req_dropped", mem_req, 0);
        release_rsp();
        chk("lw_back_idle", req_ready, 1);
        chk("lw_rsp_cleared", rsp_valid, 0);

        // LB 0x1003 with same-cycle ack (k = 1)
        issue(33'h0_0000_1003, 1'b0, 3'b000, 32'h0);
        chk("lb_mem_be", mem_be, 4'b1000);
        chk("lb_mem_addr", mem_addr, 32'h0000_1000);
        complete(1, 32'h80FF_0000);
        chk("lb_rsp_valid", rsp_valid, 1);
        chk("lb_rsp_data", rsp_data, 32'hFFFF_FF80);
        release_rsp();

        issue(33'h0_0000_1003, 1'b0, 3'b100, 32'h0);
        complete(2, 32'h80FF_0000);
        chk("lbu_rsp_data", rsp_data, 32'h0000_0080);
        release_rsp();

        // LH 0x1006 sign-extends the upper half
        issue(33'h0_0000_1006, 1'b0, 3'b001, 32'h0);
        chk("lh_mem_be", mem_be, 4'b1100);
        complete(1, 32'h8001_0000);
        chk("lh_rsp_data", rsp_data, 32'hFFFF_8001);
        release_rsp();

        // SH 0x2002
        issue(33'h0_0000_2002, 1'b1, 3'b001, 32'h1234_ABCD);
        chk("sh_mem_we", mem_we, 1);
        chk("sh_mem_be", mem_be, 4'b1100);
        chk("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
        chk("sh_mem_addr", mem_addr, 32'h0000_2000);
        complete(2, 32'hFFFF_FFFF);
        chk("sh_rsp_data", rsp_data, 32'h0);
        chk("sh_rsp_fault", rsp_fault, 0);
        release_rsp();

        // SB replicates the low byte
        issue(33'h0_0000_2001, 1'b1, 3'b000, 32'h0000_00A5);
        chk("sb_mem_be", mem_be, 4'b0010);
        chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        complete(1, 32'h0);
        release_rsp();

        // Illegal: misaligned LW, funct3 011, store with funct3 1xx, misaligned LH
        issue(33'h0_0000_1002, 1'b0, 3'b010, 32'h0);
        chk("mis_lw_no_req", mem_req, 0);
        chk("mis_lw_valid_c1", rsp_valid, 1);
        chk("mis_lw_fault", rsp_fault, 1);
        chk("mis_lw_data", rsp_data, 0);
        release_rsp();

        issue(33'h0_0000_1000, 1'b0, 3'b011, 32'h0);
        chk("f3_011_no_req", mem_req, 0);
        chk("f3_011_fault", rsp_fault, 1);
        release_rsp();

        issue(33'h0_0000_1000, 1'b1, 3'b100, 32'h0);
        chk("st_1xx_fault", rsp_fault, 1);
        release_rsp();

        issue(33'h0_0000_1001, 1'b0, 3'b101, 32'h0);
        chk("lhu_odd_fault", rsp_fault, 1);
        release_rsp();

        // Carry-out is reported but not a fault; response held while rsp_ready low
        issue(33'h1_0000_0004, 1'b0, 3'b010, 32'h0);
        chk("wrap_mem_addr", mem_addr, 32'h0000_0004);
        complete(1, 32'h1234_5678);
        req_valid = 1'b1;
        adr_sum   = 33'h0_0000_0100;
        funct3    = 3'b010;
        is_store  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, 32'h1234_5678);
            chk("hold_wrap", rsp_wrap, 1);
            chk("hold_fault", rsp_fault, 0);
            chk("hold_not_ready", req_ready, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        release_rsp();
        chk("wrap_cleared", rsp_wrap, 0);
        chk("no_spurious_accept", req_ready, 1);

`ifdef LSU_TIMEOUT_EN
        // No ack: mem_req high in cycles 1..4, fault response in cycle 5
        issue(33'h0_0000_3000, 1'b0, 3'b010, 32'h0);
        repeat (3) @(negedge clk);
        chk("to_req_c4", mem_req, 1);
        @(negedge clk);
        chk("to_req_dropped", mem_req, 0);
        chk("to_valid", rsp_valid, 1);
        chk("to_fault", rsp_fault, 1);
        chk("to_data", rsp_data, 0);
        release_rsp();
`endif

        // Asynchronous reset mid-ISSUE
        issue(33'h0_0000_4000, 1'b0, 3'b010, 32'h0);
        chk("rst_mid_req_before", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_drop", mem_req, 0);
        chk("rst_mid_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_req", mem_req, 0);

        issue(33'h0_0000_0010, 1'b0, 3'b010, 32'h0);
        complete(1, 32'hCAFE_F00D);
        chk("post_rst_lw", rsp_data, 32'hCAFE_F00D);
        release_rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
